// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage operand muxes.
// Keeps a shadow of destination info for EX/MEM/WB and builds the forward
// selects, the load-use stall, the taken-branch squash and two event counters.
module fwd_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [RA_W-1:0]  id_dst,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // EX slot carries source info too, since forwarding is decided there
   logic            ex_v, ex_rw, ex_mr, ex_urs, ex_urt;
   logic [RA_W-1:0] ex_dst, ex_rs, ex_rt;
   logic            mem_v, mem_rw, mem_mr;
   logic [RA_W-1:0] mem_dst;
   logic            wb_v, wb_rw, wb_mr;
   logic [RA_W-1:0] wb_dst;

   logic mem_wr, wb_wr, ld_hit;

   // a slot can only be a forwarding source if it writes a non-zero register
   assign mem_wr = mem_v & mem_rw & (mem_dst != '0);
   assign wb_wr  = wb_v  & wb_rw  & (wb_dst  != '0);

   // forward selects: MEM result beats WB value, register file otherwise
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (ex_v && ex_urs) begin
         if (mem_wr && mem_dst == ex_rs)     fwd_a_sel = 2'b01;
         else if (wb_wr && wb_dst == ex_rs)  fwd_a_sel = 2'b10;
      end
      if (ex_v && ex_urt) begin
         if (mem_wr && mem_dst == ex_rt)     fwd_b_sel = 2'b01;
         else if (wb_wr && wb_dst == ex_rt)  fwd_b_sel = 2'b10;
      end
   end

   // load-use detection; a taken branch squashes ID so it never stalls
   always_comb begin
      ld_hit      = ex_v & ex_mr & ex_rw & (ex_dst != '0) &
                    ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));
      stall       = id_valid & ld_hit & ~ex_branch_taken;
      pc_write    = ~stall;
      ifid_write  = ~stall;
      ifid_flush  = ex_branch_taken;
      idex_bubble = stall | ex_branch_taken;
   end

   // shadow pipeline advance; a bubble enters EX on stall or squash
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_v  <= 1'b0;
         mem_v <= 1'b0;
         wb_v  <= 1'b0;
      end else begin
         wb_v    <= mem_v;
         wb_dst  <= mem_dst;
         wb_rw   <= mem_rw;
         wb_mr   <= mem_mr;
         mem_v   <= ex_v;
         mem_dst <= ex_dst;
         mem_rw  <= ex_rw;
         mem_mr  <= ex_mr;
         ex_v    <= id_valid & ~idex_bubble;
         ex_dst  <= id_dst;
         ex_rw   <= id_regwrite;
         ex_mr   <= id_memread;
         ex_rs   <= id_rs;
         ex_rt   <= id_rt;
         ex_urs  <= id_use_rs;
         ex_urt  <= id_use_rt;
      end
   end

   // saturating stall / flush event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1)           stall_cnt <= stall_cnt + 1'b1;
         if (ex_branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
